dispatch_credit_ctrl: RTL and testbench
=======================================

# dispatch_credit_ctrl

- Sequences the 3-wide dispatch stage.
- Keeps registered free-slot credits for the ROB, reservation station, store queue and physical-register free list.
- Generates per-lane `d_stall` so that only instructions whose resources are guaranteed are dispatched, in order.
- Holds dispatch off for a fixed recovery window after a branch-mispredict squash while the back-end structures rebuild.

## Interface
Parameters:
- `ROB_SIZE`, 32: ROB entries.
- `RS_SIZE`, 16: RS entries.
- `SQ_SIZE`, 8: store queue entries.
- `PR_FREE`, 32: free physical registers at reset.
- `RECOVER_CYCLES`, 2: dispatch-blocked cycles after a squash; must be ≥1.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `dis_valid` in [2:0]: lane holds a valid instruction. Lane 2 is oldest.
- `dis_needs_pr` in [2:0]: lane writes a non-zero architectural destination.
- `dis_is_store` in [2:0]: lane is a store.
- `dis_taken` in [2:0]: lane is predicted taken.
- `rob_release` in 2: ROB entries retired this cycle, 0–3.
- `rs_release` in 2: RS entries issued this cycle, 0–3.
- `sq_release` in 2: SQ entries retired this cycle, 0–3.
- `pr_release` in 2: physical registers returned to the free list this cycle, 0–3.
- `squash` in 1: one-cycle mispredict recovery pulse.
- `sq_free_in` in $clog2(SQ_SIZE+1): SQ free count after squash, sampled with `squash`.
- `pr_free_in` in $clog2(PR_FREE+1): free-list count after squash, sampled with `squash`.
- `d_stall` out [2:0]: lane must not dispatch.
- `dis_fire` out [2:0]: lane dispatches this cycle.
- `rob_credit`, `rs_credit`, `sq_credit`, `pr_credit` out: registered credit counts, each of width $clog2(SIZE+1).
- `recovering` out 1: FSM is in RECOVER.

## Operation
FSM has two states, RUN and RECOVER.
- Reset: state RUN.
- Reset credits: ROB=ROB_SIZE, RS=RS_SIZE, SQ=SQ_SIZE, PR=PR_FREE.
- Reset outputs: `d_stall`=3'b000, `dis_fire`=0, `recovering`=0.

Lane acceptance in RUN, evaluated lane 2, then 1, then 0:
- Each valid lane requires:
  - 1 ROB credit;
  - 1 RS credit;
  - 1 SQ credit if `dis_is_store`;
  - 1 PR credit if `dis_needs_pr`.
- Requirements are cumulative across accepted older lanes. They are checked against registered credits only; same-cycle releases are not visible.
- A valid lane is accepted iff:
  - every older valid lane was accepted, and
  - the cumulative need fits in all four credits.
- Invalid lanes consume nothing and never block younger lanes.
- The first valid lane that fails sets `d_stall` for itself and for every younger lane.
- Lanes younger than an accepted `dis_taken` lane are dropped:
  - `d_stall`=0, `dis_fire`=0, no credit consumed.
  - If the taken lane itself stalls, the younger lanes stall too.
- `dis_fire[i]` = valid & accepted & not dropped.

Credit update, every RUN cycle:
- next = credit − (accepted need) + release.
- Clamp to the parameter maximum.
- A release above the maximum is a bench assertion failure.

Squash (any state):
- In the squash cycle: `d_stall`=3'b111 and `dis_fire`=0.
- At the next edge:
  - ROB=ROB_SIZE, RS=RS_SIZE;
  - SQ=`sq_free_in`, PR=`pr_free_in`;
  - releases that cycle are ignored;
  - state becomes RECOVER with the counter at RECOVER_CYCLES−1.

RECOVER:
- `d_stall`=3'b111, `dis_fire`=0, `recovering`=1.
- Releases are applied normally.
- Counter decrements each cycle; at 0 the FSM returns to RUN.
- A squash in RECOVER reloads the credits and restarts the counter.

Reset asserted mid-operation returns all state and outputs to reset values immediately.

## Timing
- `d_stall` and `dis_fire` are combinational from the registered credits, the FSM state and the current lane inputs. No added latency.
- Credits and state update on the rising edge.
- After a squash pulse in cycle T:
  - dispatch is blocked in cycles T through T+RECOVER_CYCLES;
  - first possible fire is at T+RECOVER_CYCLES+1.
- A resource freed in cycle T is usable for dispatch in cycle T+1.

## Test plan
- Reset with parameter defaults:
  - all credits at full (32/16/8/32);
  - `d_stall`=0 and `recovering`=0 while `reset` is low;
  - first cycle after release: 3 valid lanes → `dis_fire`=3'b111.
- ROB fill, RS_SIZE=64, no releases, 3 valid non-store lanes per cycle:
  - 10 cycles fire 3'b111 and leave `rob_credit`=2;
  - cycle 11: `dis_fire`=3'b110, `d_stall`=3'b001;
  - then `d_stall`=3'b111 until `rob_release`=1 → next cycle `dis_fire`=3'b100.
- SQ limit: `sq_credit`=1, all three lanes stores:
  - `dis_fire`=3'b100, `d_stall`=3'b011.
  - Same cycle with `sq_release`=2 → next cycle `sq_credit`=2.
- Taken branch: `dis_taken`=3'b010, all valid, credits ample:
  - `dis_fire`=3'b110, `d_stall`=3'b000;
  - `rob_credit` drops by 2.
- Squash: `squash` in cycle T with `sq_free_in`=5, `pr_free_in`=20, RECOVER_CYCLES=2:
  - `d_stall`=3'b111 in cycles T, T+1 and T+2; `recovering`=1 in cycles T+1 and T+2;
  - credits 32/16/5/20 at T+1;
  - fire resumes at T+3.
  - A second squash at T+1 delays resumption to T+4.
- Simultaneous events: `rob_credit`=3, 3 lanes fire and `rob_release`=3 in the same cycle → next `rob_credit`=3.
  - Repeat with `rob_credit`=0: lanes stall and the release is applied, giving `rob_credit`=3.

Source files
------------

// File: rtl/dispatch_credit_ctrl.sv
// Credit tracking and in-order lane acceptance for the 3-wide dispatch stage,
// with a fixed dispatch-blocking recovery window after a mispredict squash.
module dispatch_credit_ctrl #(
  parameter int ROB_SIZE       = 32,
  parameter int RS_SIZE        = 16,
  parameter int SQ_SIZE        = 8,
  parameter int PR_FREE        = 32,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [2:0]                         dis_valid,
  input  logic [2:0]                         dis_needs_pr,
  input  logic [2:0]                         dis_is_store,
  input  logic [2:0]                         dis_taken,
  input  logic [1:0]                         rob_release,
  input  logic [1:0]                         rs_release,
  input  logic [1:0]                         sq_release,
  input  logic [1:0]                         pr_release,
  input  logic                               squash,
  input  logic [$clog2(SQ_SIZE+1)-1:0]       sq_free_in,
  input  logic [$clog2(PR_FREE+1)-1:0]       pr_free_in,
  output logic [2:0]                         d_stall,
  output logic [2:0]                         dis_fire,
  output logic [$clog2(ROB_SIZE+1)-1:0]      rob_credit,
  output logic [$clog2(RS_SIZE+1)-1:0]       rs_credit,
  output logic [$clog2(SQ_SIZE+1)-1:0]       sq_credit,
  output logic [$clog2(PR_FREE+1)-1:0]       pr_credit,
  output logic                               recovering
);

  localparam int ROB_W = $clog2(ROB_SIZE + 1);
  localparam int RS_W  = $clog2(RS_SIZE + 1);
  localparam int SQ_W  = $clog2(SQ_SIZE + 1);
  localparam int PR_W  = $clog2(PR_FREE + 1);
  localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef enum logic {RUN, RECOVER} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ROB_W-1:0] rob_q, rob_d;
  logic [RS_W-1:0]  rs_q,  rs_d;
  logic [SQ_W-1:0]  sq_q,  sq_d;
  logic [PR_W-1:0]  pr_q,  pr_d;

  int   cum_slot, cum_sq, cum_pr;
  int   need_slot, need_sq, need_pr;
  logic blocked, dropped;

  function automatic int clamp_credit(input int value, input int max_value);
    return (value > max_value) ? max_value : value;
  endfunction

  // Walk lanes oldest-first; cum_* hold the resources claimed by accepted older lanes.
  always_comb begin
    d_stall   = 3'b000;
    dis_fire  = 3'b000;
    blocked   = 1'b0;
    dropped   = 1'b0;
    cum_slot  = 0;
    cum_sq    = 0;
    cum_pr    = 0;
    need_slot = 0;
    need_sq   = 0;
    need_pr   = 0;
    if (squash || state_q == RECOVER) begin
      d_stall = 3'b111;
    end else begin
      for (int i = 2; i >= 0; i--) begin
        if (blocked) begin
          d_stall[i] = 1'b1;
        end else if (!dropped && dis_valid[i]) begin
          need_slot = cum_slot + 1;
          need_sq   = cum_sq + (dis_is_store[i] ? 1 : 0);
          need_pr   = cum_pr + (dis_needs_pr[i] ? 1 : 0);
          if (need_slot <= int'(rob_q) && need_slot <= int'(rs_q) &&
              need_sq <= int'(sq_q) && need_pr <= int'(pr_q)) begin
            dis_fire[i] = 1'b1;
            cum_slot    = need_slot;
            cum_sq      = need_sq;
            cum_pr      = need_pr;
            dropped     = dis_taken[i];
          end else begin
            blocked    = 1'b1;
            d_stall[i] = 1'b1;
          end
        end
      end
    end
  end

  // Squash reloads credits and discards that cycle's releases; otherwise consume and release.
  always_comb begin
    if (squash) begin
      rob_d = ROB_W'(ROB_SIZE);
      rs_d  = RS_W'(RS_SIZE);
      sq_d  = sq_free_in;
      pr_d  = pr_free_in;
    end else begin
      rob_d = ROB_W'(clamp_credit(int'(rob_q) - cum_slot + int'(rob_release), ROB_SIZE));
      rs_d  = RS_W'(clamp_credit(int'(rs_q) - cum_slot + int'(rs_release), RS_SIZE));
      sq_d  = SQ_W'(clamp_credit(int'(sq_q) - cum_sq + int'(sq_release), SQ_SIZE));
      pr_d  = PR_W'(clamp_credit(int'(pr_q) - cum_pr + int'(pr_release), PR_FREE));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      rob_q   <= ROB_W'(ROB_SIZE);
      rs_q    <= RS_W'(RS_SIZE);
      sq_q    <= SQ_W'(SQ_SIZE);
      pr_q    <= PR_W'(PR_FREE);
    end else begin
      rob_q <= rob_d;
      rs_q  <= rs_d;
      sq_q  <= sq_d;
      pr_q  <= pr_d;
      if (squash) begin
        state_q <= RECOVER;
        cnt_q   <= CNT_W'(RECOVER_CYCLES - 1);
      end else if (state_q == RECOVER) begin
        if (cnt_q == '0) state_q <= RUN;
        else             cnt_q   <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign rob_credit = rob_q;
  assign rs_credit  = rs_q;
  assign sq_credit  = sq_q;
  assign pr_credit  = pr_q;
  assign recovering = (state_q == RECOVER);

endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// Scoreboard bench for dispatch_credit_ctrl: default instance plus an RS_SIZE=64
// instance used for the ROB fill scenario, both driven from the same inputs.
module tb_dispatch_credit_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] dis_valid, dis_needs_pr, dis_is_store, dis_taken;
  logic [1:0] rob_release, rs_release, sq_release, pr_release;
  logic       squash;
  logic [3:0] sq_free_in;
  logic [5:0] pr_free_in;

  logic [2:0] d_stall_a, dis_fire_a, d_stall_b, dis_fire_b;
  logic [5:0] rob_a, pr_a, rob_b, pr_b;
  logic [4:0] rs_a;
  logic [6:0] rs_b;
  logic [3:0] sq_a, sq_b;
  logic       rec_a, rec_b;

  typedef struct {
    string      name;
    logic [2:0] fire;
    logic [2:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  dispatch_credit_ctrl u_dut (
    .clock(clock), .reset(reset),
    .dis_valid(dis_valid), .dis_needs_pr(dis_needs_pr),
    .dis_is_store(dis_is_store), .dis_taken(dis_taken),
    .rob_release(rob_release), .rs_release(rs_release),
    .sq_release(sq_release), .pr_release(pr_release),
    .squash(squash), .sq_free_in(sq_free_in), .pr_free_in(pr_free_in),
    .d_stall(d_stall_a), .dis_fire(dis_fire_a),
    .rob_credit(rob_a), .rs_credit(rs_a), .sq_credit(sq_a), .pr_credit(pr_a),
    .recovering(rec_a)
  );

  dispatch_credit_ctrl #(.RS_SIZE(64)) u_dut_rs64 (
    .clock(clock), .reset(reset),
    .dis_valid(dis_valid), .dis_needs_pr(dis_needs_pr),
    .dis_is_store(dis_is_store), .dis_taken(dis_taken),
    .rob_release(rob_release), .rs_release(rs_release),
    .sq_release(sq_release), .pr_release(pr_release),
    .squash(squash), .sq_free_in(sq_free_in), .pr_free_in(pr_free_in),
    .d_stall(d_stall_b), .dis_fire(dis_fire_b),
    .rob_credit(rob_b), .rs_credit(rs_b), .sq_credit(sq_b), .pr_credit(pr_b),
    .recovering(rec_b)
  );

  task automatic clear_inputs();
    dis_valid    = 3'b000;
    dis_needs_pr = 3'b000;
    dis_is_store = 3'b000;
    dis_taken    = 3'b000;
    rob_release  = 2'd0;
    rs_release   = 2'd0;
    sq_release   = 2'd0;
    pr_release   = 2'd0;
    squash       = 1'b0;
    sq_free_in   = 4'd0;
    pr_free_in   = 6'd0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic push(input string name, input logic [2:0] fire, input logic [2:0] stall);
    exp_t e;
    e.name  = name;
    e.fire  = fire;
    e.stall = stall;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_vec++;
    if ({rob_a, rs_a, sq_a, pr_a} !== {6'd32, 5'd16, 4'd8, 6'd32}) begin
      n_err++;
      $display("FAIL reset_credits: got %0d/%0d/%0d/%0d expected 32/16/8/32", rob_a, rs_a, sq_a, pr_a);
    end
    n_vec++;
    if (d_stall_a !== 3'b000 || dis_fire_a !== 3'b000 || rec_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: stall=%b fire=%b rec=%b expected 000/000/0", d_stall_a, dis_fire_a, rec_a);
    end
    n_vec++;
    if (rs_b !== 7'd64) begin
      n_err++;
      $display("FAIL reset_rs64: got %0d expected 64", rs_b);
    end
    step();
    reset = 1'b1;
    dis_valid = 3'b111;
    push("reset_first_fire", 3'b111, 3'b000);
    @(negedge clock);
    e = exp_q.pop_front();
    n_vec++;
    if (dis_fire_a !== e.fire || d_stall_a !== e.stall) begin
      n_err++;
      $display("FAIL %s: fire=%b stall=%b expected fire=%b stall=%b", e.name, dis_fire_a, d_stall_a, e.fire, e.stall);
    end
    step();
  endtask

  task automatic test_rob_fill();
    exp_t e;
    do_reset();
    dis_valid = 3'b111;
    for (int c = 0; c < 14; c++) begin
      if (c < 10)       push($sformatf("rob_fill_c%0d", c), 3'b111, 3'b000);
      else if (c == 10) push("rob_fill_partial", 3'b110, 3'b001);
      else if (c < 13)  push($sformatf("rob_fill_full_c%0d", c), 3'b000, 3'b111);
      else              push("rob_fill_after_release", 3'b100, 3'b011);
      rob_release = (c == 12) ? 2'd1 : 2'd0;
      @(negedge clock);
      e = exp_q.pop_front();
      n_vec++;
      if (dis_fire_b !== e.fire || d_stall_b !== e.stall) begin
        n_err++;
        $display("FAIL %s: fire=%b stall=%b expected fire=%b stall=%b", e.name, dis_fire_b, d_stall_b, e.fire, e.stall);
      end
      if (c == 10) begin
        n_vec++;
        if (rob_b !== 6'd2) begin
          n_err++;
          $display("FAIL rob_fill_credit: got %0d expected 2", rob_b);
        end
      end
      step();
    end
    rob_release = 2'd0;
  endtask

  task automatic test_sq_limit();
    exp_t e;
    do_reset();
    dis_valid    = 3'b100;
    dis_is_store = 3'b100;
    for (int c = 0; c < 11; c++) begin
      if (c == 7) begin
        n_vec++;
        if (sq_a !== 4'd1) begin
          n_err++;
          $display("FAIL sq_fill_credit: got %0d expected 1", sq_a);
        end
      end
      sq_release = 2'd0;
      if (c < 7) begin
        push($sformatf("sq_fill_c%0d", c), 3'b100, 3'b000);
      end else if (c == 7) begin
        dis_valid = 3'b111; dis_is_store = 3'b111; sq_release = 2'd2;
        push("sq_limit_one", 3'b100, 3'b011);
      end else if (c == 8) begin
        push("sq_limit_two", 3'b110, 3'b001);
      end else if (c == 9) begin
        dis_valid = 3'b011; dis_is_store = 3'b000;
        push("sq_invalid_oldest", 3'b011, 3'b000);
      end else begin
        dis_valid = 3'b111; dis_is_store = 3'b100;
        push("sq_oldest_stalls", 3'b000, 3'b111);
      end
      @(negedge clock);
      e = exp_q.pop_front();
      n_vec++;
      if (dis_fire_a !== e.fire || d_stall_a !== e.stall) begin
        n_err++;
        $display("FAIL %s: fire=%b stall=%b expected fire=%b stall=%b", e.name, dis_fire_a, d_stall_a, e.fire, e.stall);
      end
      step();
      if (c == 7) begin
        n_vec++;
        if (sq_a !== 4'd2) begin
          n_err++;
          $display("FAIL sq_release_credit: got %0d expected 2", sq_a);
        end
      end
    end
  endtask

  task automatic test_taken();
    exp_t e;
    do_reset();
    dis_valid    = 3'b111;
    dis_needs_pr = 3'b111;
    for (int c = 0; c < 2; c++) begin
      dis_taken = (c == 0) ? 3'b010 : 3'b100;
      if (c == 0) push("taken_lane1", 3'b110, 3'b000);
      else        push("taken_lane2", 3'b100, 3'b000);
      @(negedge clock);
      e = exp_q.pop_front();
      n_vec++;
      if (dis_fire_a !== e.fire || d_stall_a !== e.stall) begin
        n_err++;
        $display("FAIL %s: fire=%b stall=%b expected fire=%b stall=%b", e.name, dis_fire_a, d_stall_a, e.fire, e.stall);
      end
      step();
      if (c == 0) begin
        n_vec++;
        if (rob_a !== 6'd30 || pr_a !== 6'd30) begin
          n_err++;
          $display("FAIL taken_credits: rob=%0d pr=%0d expected 30/30", rob_a, pr_a);
        end
      end
    end
    n_vec++;
    if (rob_a !== 6'd29) begin
      n_err++;
      $display("FAIL taken_lane2_rob: got %0d expected 29", rob_a);
    end
  endtask

  task automatic test_squash();
    exp_t e;
    // Single squash: T at c==1, fire resumes at c==4 (T+3).
    do_reset();
    dis_valid    = 3'b111;
    dis_needs_pr = 3'b111;
    for (int c = 0; c < 5; c++) begin
      squash = (c == 1);
      sq_free_in  = 4'd5;
      pr_free_in  = 6'd20;
      rob_release = (c == 1) ? 2'd3 : 2'd0;
      pr_release  = (c == 1) ? 2'd3 : 2'd0;
      if (c == 0 || c == 4) push($sformatf("squash1_c%0d", c), 3'b111, 3'b000);
      else                  push($sformatf("squash1_c%0d", c), 3'b000, 3'b111);
      @(negedge clock);
      e = exp_q.pop_front();
      n_vec++;
      if (dis_fire_a !== e.fire || d_stall_a !== e.stall) begin
        n_err++;
        $display("FAIL %s: fire=%b stall=%b expected fire=%b stall=%b", e.name, dis_fire_a, d_stall_a, e.fire, e.stall);
      end
      n_vec++;
      if (rec_a !== (c == 2 || c == 3)) begin
        n_err++;
        $display("FAIL squash1_rec_c%0d: got %b expected %b", c, rec_a, (c == 2 || c == 3));
      end
      if (c == 2) begin
        n_vec++;
        if ({rob_a, rs_a, sq_a, pr_a} !== {6'd32, 5'd16, 4'd5, 6'd20}) begin
          n_err++;
          $display("FAIL squash1_reload: got %0d/%0d/%0d/%0d expected 32/16/5/20", rob_a, rs_a, sq_a, pr_a);
        end
      end
      step();
    end
    // Double squash: T at c==0, second at c==1, fire resumes at c==4 (T+4).
    do_reset();
    dis_valid = 3'b111;
    for (int c = 0; c < 5; c++) begin
      squash     = (c < 2);
      sq_free_in = (c == 0) ? 4'd5 : 4'd6;
      pr_free_in = (c == 0) ? 6'd20 : 6'd21;
      pr_release = (c == 2) ? 2'd2 : 2'd0;
      if (c == 4) push("squash2_resume", 3'b111, 3'b000);
      else        push($sformatf("squash2_c%0d", c), 3'b000, 3'b111);
      @(negedge clock);
      e = exp_q.pop_front();
      n_vec++;
      if (dis_fire_a !== e.fire || d_stall_a !== e.stall) begin
        n_err++;
        $display("FAIL %s: fire=%b stall=%b expected fire=%b stall=%b", e.name, dis_fire_a, d_stall_a, e.fire, e.stall);
      end
      if (c == 3) begin
        n_vec++;
        if (rec_a !== 1'b1 || sq_a !== 4'd6 || pr_a !== 6'd23) begin
          n_err++;
          $display("FAIL squash2_state: rec=%b sq=%0d pr=%0d expected 1/6/23", rec_a, sq_a, pr_a);
        end
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    rs_release = 2'd3;
    for (int c = 0; c < 13; c++) begin
      dis_valid   = (c == 9) ? 3'b110 : 3'b111;
      rob_release = (c == 10 || c == 12) ? 2'd3 : 2'd0;
      if (c == 9)       push("b2b_pair", 3'b110, 3'b000);
      else if (c == 12) push("b2b_empty_release", 3'b000, 3'b111);
      else              push($sformatf("b2b_c%0d", c), 3'b111, 3'b000);
      @(negedge clock);
      e = exp_q.pop_front();
      n_vec++;
      if (dis_fire_a !== e.fire || d_stall_a !== e.stall) begin
        n_err++;
        $display("FAIL %s: fire=%b stall=%b expected fire=%b stall=%b", e.name, dis_fire_a, d_stall_a, e.fire, e.stall);
      end
      step();
      if (c >= 9) begin
        n_vec++;
        if (rob_a !== ((c == 11) ? 6'd0 : 6'd3) || rs_a !== 5'd16) begin
          n_err++;
          $display("FAIL b2b_credit_c%0d: rob=%0d rs=%0d expected %0d/16", c, rob_a, rs_a, (c == 11) ? 0 : 3);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_clamp_and_async_reset();
    exp_t e;
    do_reset();
    rob_release = 2'd3; rs_release = 2'd3; sq_release = 2'd3; pr_release = 2'd3;
    push("clamp_idle", 3'b000, 3'b000);
    @(negedge clock);
    e = exp_q.pop_front();
    n_vec++;
    if (dis_fire_a !== e.fire || d_stall_a !== e.stall) begin
      n_err++;
      $display("FAIL %s: fire=%b stall=%b expected fire=%b stall=%b", e.name, dis_fire_a, d_stall_a, e.fire, e.stall);
    end
    step();
    n_vec++;
    if ({rob_a, rs_a, sq_a, pr_a} !== {6'd32, 5'd16, 4'd8, 6'd32}) begin
      n_err++;
      $display("FAIL clamp_credits: got %0d/%0d/%0d/%0d expected 32/16/8/32", rob_a, rs_a, sq_a, pr_a);
    end
    clear_inputs();
    dis_valid = 3'b111; dis_is_store = 3'b111; squash = 1'b1;
    sq_free_in = 4'd1; pr_free_in = 6'd2;
    step();
    squash = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (rec_a !== 1'b0 || d_stall_a !== 3'b000 ||
        {rob_a, rs_a, sq_a, pr_a} !== {6'd32, 5'd16, 4'd8, 6'd32}) begin
      n_err++;
      $display("FAIL async_reset: rec=%b stall=%b credits=%0d/%0d/%0d/%0d expected 0/000/32/16/8/32",
               rec_a, d_stall_a, rob_a, rs_a, sq_a, pr_a);
    end
    clear_inputs();
    step();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rob_fill();
    test_sq_limit();
    test_taken();
    test_squash();
    test_back_to_back();
    test_clamp_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
